// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and types.
package mips_pkg;

  localparam int unsigned NB_DATA = 32;

  localparam logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [NB_DATA-1:0] NOP_WORD  = 32'h0000_0000;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } fetch_state_e;

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction store: synchronous write, combinational read.
import mips_pkg::*;

module instruction_memory #(
  parameter int unsigned NB_DATA   = mips_pkg::NB_DATA,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [NB_DATA-1:0] wr_addr,
  input  logic [NB_DATA-1:0] wr_data,
  input  logic [NB_DATA-1:0] rd_addr,
  output logic [NB_DATA-1:0] rd_data
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);

  logic [NB_DATA-1:0] mem [MEM_DEPTH];

  // Byte addresses: drop the byte offset and wrap above the array size.
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          unused_addr_bits;

  assign wr_idx = wr_addr[AW+1:2];
  assign rd_idx = rd_addr[AW+1:2];
  assign unused_addr_bits = ^{wr_addr[NB_DATA-1:AW+2], wr_addr[1:0],
                              rd_addr[NB_DATA-1:AW+2], rd_addr[1:0]};

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC register, instruction memory and the IF/ID pipeline register.
import mips_pkg::*;

module instruction_fetch #(
  parameter int unsigned NB_DATA   = mips_pkg::NB_DATA,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_jump,
  input  logic [NB_DATA-1:0] i_addr2jump,
  input  logic               i_stall,
  input  logic               i_halt,
  input  logic               i_inst_wr_en,
  input  logic [NB_DATA-1:0] i_inst_wr_addr,
  input  logic [NB_DATA-1:0] i_inst_wr_data,
  output logic [NB_DATA-1:0] o_instruction,
  output logic [NB_DATA-1:0] o_pcounter4,
  output logic [NB_DATA-1:0] o_pc,
  output logic               o_halted
);

  fetch_state_e       state, state_next;
  logic [NB_DATA-1:0] pc, pc_next;
  logic [NB_DATA-1:0] inst, inst_next;
  logic [NB_DATA-1:0] pc4, pc4_next;
  logic [NB_DATA-1:0] rd_data;
  logic [NB_DATA-1:0] pc_plus4;

  instruction_memory #(
    .NB_DATA   (NB_DATA),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_imem (
    .clk     (clk),
    .wr_en   (i_inst_wr_en),
    .wr_addr (i_inst_wr_addr),
    .wr_data (i_inst_wr_data),
    .rd_addr (pc),
    .rd_data (rd_data)
  );

  assign pc_plus4 = pc + NB_DATA'(4);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_RUN;
      pc    <= '0;
      inst  <= '0;
      pc4   <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      inst  <= inst_next;
      pc4   <= pc4_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    inst_next  = inst;
    pc4_next   = pc4;
    if (i_halt || state == ST_HALTED) begin
      // frozen; program-load writes are handled by the memory regardless
    end else if (i_stall) begin
      // hold PC and IF/ID; ID re-issues any pending jump next cycle
    end else if (i_jump) begin
      // redirect wins over a HALT fetched on the wrong path
      pc_next   = {i_addr2jump[NB_DATA-1:2], 2'b00};
      inst_next = NOP_WORD;
      pc4_next  = pc_plus4;
    end else if (rd_data == HALT_WORD) begin
      state_next = ST_HALTED;
      inst_next  = HALT_WORD;
      pc4_next   = pc_plus4;
    end else begin
      pc_next   = pc_plus4;
      inst_next = rd_data;
      pc4_next  = pc_plus4;
    end
  end

  assign o_instruction = inst;
  assign o_pcounter4   = pc4;
  assign o_pc          = pc;
  assign o_halted      = (state == ST_HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for the IF stage.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump;
  logic [31:0] addr2jump;
  logic        stall;
  logic        halt;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [31:0] instruction;
  logic [31:0] pcounter4;
  logic [31:0] pc;
  logic        halted;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] A0 = 32'h2001_0005, A1 = 32'h2002_0007, A2 = 32'h0022_1820,
                          A3 = 32'h0043_2022, A4 = 32'hAC04_0010, B0 = 32'h8C05_0010,
                          A5 = 32'hCAFE_0005;

  instruction_fetch #(
    .NB_DATA   (32),
    .MEM_DEPTH (256)
  ) dut (
    .clk            (clk),
    .i_rst_n        (rst_n),
    .i_jump         (jump),
    .i_addr2jump    (addr2jump),
    .i_stall        (stall),
    .i_halt         (halt),
    .i_inst_wr_en   (wr_en),
    .i_inst_wr_addr (wr_addr),
    .i_inst_wr_data (wr_data),
    .o_instruction  (instruction),
    .o_pcounter4    (pcounter4),
    .o_pc           (pc),
    .o_halted       (halted)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic enter_reset();
    rst_n = 1'b0; jump = 1'b0; stall = 1'b0; halt = 1'b0; addr2jump = '0;
    #1;
  endtask

  task automatic load_linear();
    load(32'h00, A0); load(32'h04, A1); load(32'h08, A2);
    load(32'h0C, A3); load(32'h10, A4); load(32'h14, A5); load(32'h40, B0);
  endtask

  task automatic test_reset();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    enter_reset();
    n_checks++;
    if ({instruction, pcounter4, pc, halted} !== {32'h0, 32'h0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state act inst=%h pc4=%h pc=%h halted=%b exp all zero",
               instruction, pcounter4, pc, halted);
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp_i [4]  = '{A0, A1, HALT, HALT};
    logic [31:0] exp_p4 [4] = '{32'h4, 32'h8, 32'hC, 32'hC};
    logic [31:0] exp_pc [4] = '{32'h4, 32'h8, 32'h8, 32'h8};
    logic        exp_h [4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    enter_reset();
    load(32'h0, A0); load(32'h4, A1); load(32'h8, HALT);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if ({instruction, pcounter4, pc, halted} !== {exp_i[i], exp_p4[i], exp_pc[i], exp_h[i]}) begin
        n_fail++;
        $display("FAIL basic_seq[%0d] act %h/%h/%h/%b exp %h/%h/%h/%b", i,
                 instruction, pcounter4, pc, halted, exp_i[i], exp_p4[i], exp_pc[i], exp_h[i]);
      end
    end
  endtask

  task automatic test_jump();
    enter_reset();
    load_linear();
    rst_n = 1'b1;
    repeat (4) step();
    n_checks++;
    if ({instruction, pc} !== {A3, 32'h10}) begin
      n_fail++; $display("FAIL jump_pre act %h/%h exp %h/%h", instruction, pc, A3, 32'h10);
    end
    jump = 1'b1; addr2jump = 32'h43;
    step();
    jump = 1'b0;
    n_checks++;
    if ({instruction, pcounter4, pc} !== {32'h0, 32'h14, 32'h40}) begin
      n_fail++; $display("FAIL jump_bubble act %h/%h/%h exp 0/14/40", instruction, pcounter4, pc);
    end
    step();
    n_checks++;
    if ({instruction, pcounter4, pc} !== {B0, 32'h44, 32'h44}) begin
      n_fail++; $display("FAIL jump_target act %h/%h/%h exp %h/44/44", instruction, pcounter4, pc, B0);
    end
    // Upper address bits wrap: 0x440 aliases word 0x40.
    jump = 1'b1; addr2jump = 32'h442;
    step();
    jump = 1'b0;
    step();
    n_checks++;
    if ({instruction, pcounter4, pc} !== {B0, 32'h444, 32'h444}) begin
      n_fail++; $display("FAIL jump_wrap act %h/%h/%h exp %h/444/444", instruction, pcounter4, pc, B0);
    end
  endtask

  task automatic test_stall();
    enter_reset();
    rst_n = 1'b1;
    repeat (2) step();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if ({instruction, pcounter4, pc} !== {A1, 32'h8, 32'h8}) begin
        n_fail++; $display("FAIL stall_hold[%0d] act %h/%h/%h exp %h/8/8", i, instruction, pcounter4, pc, A1);
      end
    end
    stall = 1'b0;
    step();
    n_checks++;
    if ({instruction, pcounter4, pc} !== {A2, 32'hC, 32'hC}) begin
      n_fail++; $display("FAIL stall_release act %h/%h/%h exp %h/c/c", instruction, pcounter4, pc, A2);
    end
  endtask

  task automatic test_stall_jump();
    stall = 1'b1; jump = 1'b1; addr2jump = 32'h40;
    step();
    stall = 1'b0;
    n_checks++;
    if ({instruction, pcounter4, pc} !== {A2, 32'hC, 32'hC}) begin
      n_fail++; $display("FAIL stall_jump_hold act %h/%h/%h exp %h/c/c", instruction, pcounter4, pc, A2);
    end
    step();
    jump = 1'b0;
    n_checks++;
    if ({instruction, pcounter4, pc} !== {32'h0, 32'h10, 32'h40}) begin
      n_fail++; $display("FAIL stall_jump_redirect act %h/%h/%h exp 0/10/40", instruction, pcounter4, pc);
    end
    step();
    n_checks++;
    if (instruction !== B0) begin
      n_fail++; $display("FAIL stall_jump_target act %h exp %h", instruction, B0);
    end
  endtask

  task automatic test_halt_jump();
    enter_reset();
    load(32'hC, HALT);
    rst_n = 1'b1;
    repeat (3) step();
    jump = 1'b1; addr2jump = 32'h40;
    step();
    jump = 1'b0;
    n_checks++;
    if ({instruction, pc, halted} !== {32'h0, 32'h40, 1'b0}) begin
      n_fail++; $display("FAIL halt_jump_discard act %h/%h/%b exp 0/40/0", instruction, pc, halted);
    end
    step();
    n_checks++;
    if ({instruction, pc, halted} !== {B0, 32'h44, 1'b0}) begin
      n_fail++; $display("FAIL halt_jump_continue act %h/%h/%b exp %h/44/0", instruction, pc, halted, B0);
    end
  endtask

  task automatic test_freeze_reset();
    logic [31:0] exp_i [6] = '{A0, A1, A2, A3, A4, 32'h1234_5678};
    enter_reset();
    load(32'hC, A3); load(32'h14, A5);
    rst_n = 1'b1;
    repeat (2) step();
    halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      // Program load still lands while frozen.
      wr_en = (i == 1); wr_addr = 32'h14; wr_data = 32'h1234_5678;
      step();
      n_checks++;
      if ({instruction, pcounter4, pc, halted} !== {A1, 32'h8, 32'h8, 1'b0}) begin
        n_fail++; $display("FAIL freeze_hold[%0d] act %h/%h/%h/%b exp %h/8/8/0", i,
                           instruction, pcounter4, pc, halted, A1);
      end
    end
    wr_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({instruction, pcounter4, pc, halted} !== {32'h0, 32'h0, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL async_reset act %h/%h/%h/%b exp all zero", instruction, pcounter4, pc, halted);
    end
    halt = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if ({instruction, pcounter4, pc} !== {exp_i[i], 32'(4*(i+1)), 32'(4*(i+1))}) begin
        n_fail++; $display("FAIL rerun[%0d] act %h/%h/%h exp %h/%h/%h", i, instruction, pcounter4, pc,
                           exp_i[i], 32'(4*(i+1)), 32'(4*(i+1)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_jump();
    test_stall();
    test_stall_jump();
    test_halt_jump();
    test_freeze_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
